// File: rtl/sfx_arbiter.sv
// sfx_arbiter: shares one speaker pin between the background-music generator
// and four fixed square-wave sound effects. Music is paused (frozen via
// music_enable) while an effect plays and resumes afterwards. Effect
// requests are latched in a pending register and served by fixed priority,
// bit 0 highest. A running effect is never preempted.
module sfx_arbiter #(
    parameter int PRESCALE   = 64,
    parameter int NOTE_TICKS = 4_000_000,
    parameter int GAP_TICKS  = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       music_req,
    input  logic [3:0] sfx_req,
    input  logic       music_speaker,
    output logic       music_enable,
    output logic       speaker,
    output logic [3:0] sfx_grant,
    output logic       sfx_busy,
    output logic       sfx_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUSIC = 2'd1,
        ST_PLAY  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Prescale counter width; a prescale of 1 still needs a 1-bit counter.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [31:0]   NOTE_LAST = 32'(NOTE_TICKS - 1);
    localparam logic [31:0]   GAP_LAST  = 32'(GAP_TICKS - 1);

    // Half-period divider for a given effect (one-hot grant) and note index.
    function automatic logic [8:0] note_divider(input logic [3:0] grant,
                                                input logic [1:0] note);
        logic [8:0] div;
        case (grant)
            4'b0001: begin
                case (note)
                    2'd0:    div = 9'd341;
                    2'd1:    div = 9'd270;
                    2'd2:    div = 9'd341;
                    2'd3:    div = 9'd270;
                    default: div = 9'd341;
                endcase
            end
            4'b0010: begin
                case (note)
                    2'd0:    div = 9'd270;
                    2'd1:    div = 9'd303;
                    2'd2:    div = 9'd341;
                    2'd3:    div = 9'd383;
                    default: div = 9'd270;
                endcase
            end
            4'b0100: begin
                case (note)
                    2'd0:    div = 9'd511;
                    2'd1:    div = 9'd430;
                    2'd2:    div = 9'd361;
                    2'd3:    div = 9'd303;
                    default: div = 9'd511;
                endcase
            end
            4'b1000: begin
                case (note)
                    2'd0:    div = 9'd383;
                    2'd1:    div = 9'd430;
                    2'd2:    div = 9'd482;
                    2'd3:    div = 9'd511;
                    default: div = 9'd383;
                endcase
            end
            default: div = 9'd341;
        endcase
        return div;
    endfunction

    // Fixed-priority pick: one-hot of the lowest set bit, zero if none.
    function automatic logic [3:0] lowest_one(input logic [3:0] req);
        logic [3:0] pick;
        if (req[0]) begin
            pick = 4'b0001;
        end else if (req[1]) begin
            pick = 4'b0010;
        end else if (req[2]) begin
            pick = 4'b0100;
        end else if (req[3]) begin
            pick = 4'b1000;
        end else begin
            pick = 4'b0000;
        end
        return pick;
    endfunction

    state_t        state_r, state_s;
    logic [3:0]    pending_r, pending_s;
    logic [3:0]    clear_s;
    logic [3:0]    grant_r, grant_s;
    logic [31:0]   note_cnt_r, note_cnt_s;
    logic [1:0]    note_idx_r, note_idx_s;
    logic [31:0]   gap_cnt_r, gap_cnt_s;
    logic [PW-1:0] pre_r, pre_s;
    logic [8:0]    hp_r, hp_s;
    logic [8:0]    div_s;
    logic          sq_r, sq_s;
    logic          eval_s;
    logic          done_s;

    logic          music_enable_r, music_enable_s;
    logic          speaker_r, speaker_s;
    logic          busy_r, busy_s;
    logic          done_r;

    assign div_s = note_divider(grant_r, note_idx_r);

    // Next-state logic: sequencing of notes/gap, tone counters and grant decision.
    always_comb begin
        state_s    = state_r;
        grant_s    = grant_r;
        clear_s    = 4'b0000;
        note_cnt_s = note_cnt_r;
        note_idx_s = note_idx_r;
        gap_cnt_s  = gap_cnt_r;
        pre_s      = pre_r;
        hp_s       = hp_r;
        sq_s       = sq_r;
        eval_s     = 1'b0;
        done_s     = 1'b0;

        case (state_r)
            ST_IDLE, ST_MUSIC: begin
                eval_s = 1'b1;
            end
            ST_PLAY: begin
                // Tone: prescaler counts up, half-period counter counts down
                // once per prescaler wrap; toggle when both reach zero.
                if (pre_r == PRE_LAST) begin
                    pre_s = {PW{1'b0}};
                    if (hp_r == 9'd0) begin
                        hp_s = div_s - 9'd1;
                    end else begin
                        hp_s = hp_r - 9'd1;
                    end
                end else begin
                    pre_s = pre_r + {{(PW-1){1'b0}}, 1'b1};
                    hp_s  = hp_r;
                end
                if ((pre_s == {PW{1'b0}}) && (hp_s == 9'd0)) begin
                    sq_s = ~sq_r;
                end else begin
                    sq_s = sq_r;
                end
                // Note boundary: restart tone from a clean low phase.
                if (note_cnt_r == NOTE_LAST) begin
                    note_cnt_s = 32'd0;
                    pre_s      = {PW{1'b0}};
                    hp_s       = 9'd0;
                    sq_s       = 1'b0;
                    if (note_idx_r == 2'd3) begin
                        note_idx_s = 2'd0;
                        gap_cnt_s  = 32'd0;
                        done_s     = 1'b1;
                        state_s    = ST_GAP;
                    end else begin
                        note_idx_s = note_idx_r + 2'd1;
                    end
                end else begin
                    note_cnt_s = note_cnt_r + 32'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    eval_s = 1'b1;
                end else begin
                    gap_cnt_s = gap_cnt_r + 32'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = 4'b0000;
            end
        endcase

        // Decision point: pending effects take precedence over music.
        if (eval_s) begin
            if (pending_r != 4'b0000) begin
                state_s    = ST_PLAY;
                grant_s    = lowest_one(pending_r);
                clear_s    = grant_s;
                note_cnt_s = 32'd0;
                note_idx_s = 2'd0;
                gap_cnt_s  = 32'd0;
                pre_s      = {PW{1'b0}};
                hp_s       = 9'd0;
                sq_s       = 1'b0;
            end else if (music_req) begin
                state_s = ST_MUSIC;
                grant_s = 4'b0000;
            end else begin
                state_s = ST_IDLE;
                grant_s = 4'b0000;
            end
        end else begin
            clear_s = 4'b0000;
        end
    end

    // Pending latch: a new request wins over a same-cycle grant clear.
    always_comb begin
        pending_s = (pending_r & ~clear_s) | sfx_req;
    end

    // Next values of the registered outputs, derived from the next state.
    always_comb begin
        music_enable_s = 1'b0;
        speaker_s      = 1'b0;
        busy_s         = 1'b0;
        case (state_s)
            ST_MUSIC: begin
                music_enable_s = 1'b1;
                speaker_s      = music_speaker;
            end
            ST_PLAY: begin
                speaker_s = sq_s;
                busy_s    = 1'b1;
            end
            ST_GAP: begin
                busy_s = 1'b1;
            end
            ST_IDLE: begin
                speaker_s = 1'b0;
            end
            default: begin
                speaker_s = 1'b0;
            end
        endcase
    end

    // State, counters, pending latch and tone register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            pending_r  <= 4'b0000;
            grant_r    <= 4'b0000;
            note_cnt_r <= 32'd0;
            note_idx_r <= 2'd0;
            gap_cnt_r  <= 32'd0;
            pre_r      <= {PW{1'b0}};
            hp_r       <= 9'd0;
            sq_r       <= 1'b0;
        end else begin
            state_r    <= state_s;
            pending_r  <= pending_s;
            grant_r    <= grant_s;
            note_cnt_r <= note_cnt_s;
            note_idx_r <= note_idx_s;
            gap_cnt_r  <= gap_cnt_s;
            pre_r      <= pre_s;
            hp_r       <= hp_s;
            sq_r       <= sq_s;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            music_enable_r <= 1'b0;
            speaker_r      <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            music_enable_r <= music_enable_s;
            speaker_r      <= speaker_s;
            busy_r         <= busy_s;
            done_r         <= done_s;
        end
    end

    assign music_enable = music_enable_r;
    assign speaker      = speaker_r;
    assign sfx_grant    = grant_r;
    assign sfx_busy     = busy_r;
    assign sfx_done     = done_r;

endmodule

// File: doc/sfx_arbiter.md
# sfx_arbiter

Shares the single speaker output between the background-music generator and four fixed sound effects. Background music is paused while an effect plays and resumes where it stopped. Sits between the game logic, which raises music/effect requests, and the board speaker pin. It drives the music generator's `music_enable` and muxes the generator's `speaker` output with an internal square-wave effect player.

## Interface
- `PRESCALE`, default 64: clocks per half-period divider unit. Effect half-period = divider × PRESCALE clocks.
- `NOTE_TICKS`, default 4_000_000: clocks per effect note.
- `GAP_TICKS`, default 1_000_000: silent clocks after each effect.
- `clk`  in  1: system clock, all logic on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `music_req`  in  1: level; game wants background music.
- `sfx_req`  in  4: one-cycle request pulses, bit i requests effect i. Several bits may be high at once.
- `music_speaker`  in  1: speaker output of the music generator.
- `music_enable`  out  1: enable to the music generator.
- `speaker`  out  1: speaker pin.
- `sfx_grant`  out  4: one-hot index of the effect playing; 0 otherwise.
- `sfx_busy`  out  1: high in SFX_PLAY and SFX_GAP.
- `sfx_done`  out  1: one-cycle pulse when an effect's last note ends.

## Operation
- **Pending latch.**
  - `pending[3:0]` sets on `sfx_req` bits and clears the granted bit at grant.
  - A set and a clear of the same bit in the same cycle leaves the bit set, so the effect replays.
  - Repeated requests for an already-pending effect merge into one.
- **States:** IDLE, MUSIC, SFX_PLAY, SFX_GAP.
- **IDLE / MUSIC transitions:**
  - If `pending` is nonzero, go to SFX_PLAY. The grant is the lowest set index (fixed priority, bit 0 highest).
  - Otherwise go to MUSIC if `music_req`=1, or to IDLE if `music_req`=0.
- **SFX_PLAY:**
  - Plays 4 notes of NOTE_TICKS each.
  - After note 3, pulse `sfx_done` and go to SFX_GAP.
- **SFX_GAP:**
  - Silent for GAP_TICKS, then re-evaluate as in IDLE/MUSIC. Pending effects take precedence over music.
- **Effect table** (half-period dividers, notes 0..3):
  - Effect 0: 341, 270, 341, 270.
  - Effect 1: 270, 303, 341, 383.
  - Effect 2: 511, 430, 361, 303.
  - Effect 3: 383, 430, 482, 511.
- **Tone generation.**
  - A prescale counter (0..PRESCALE-1) and a 9-bit half-period counter (divider-1 down to 0).
  - The square wave toggles when both counters are 0.
  - Both counters and the square-wave register reset to 0 at the start of every note.
- **Outputs by state:**
  - `music_enable` = 1 only in MUSIC. The music generator freezes its song position and drives 0 when disabled, so music resumes mid-song.
  - `speaker`: registered `music_speaker` in MUSIC; square wave in SFX_PLAY; 0 in IDLE and SFX_GAP.
- **Counter width:** note and gap counters are 32 bits, sized for both defaults.

## Timing
- **Reset** (asynchronous, `rst_n`=0):
  - State IDLE and `pending`=0.
  - `music_enable`, `speaker`, `sfx_grant`, `sfx_busy` and `sfx_done` all 0.
  - All counters 0.
- Reset mid-effect aborts immediately. No `sfx_done` is issued.
- All outputs are registered.
- **Request to play:**
  - `sfx_req` at edge t makes `pending` visible at t+1.
  - From IDLE or MUSIC, `sfx_grant`/`sfx_busy` rise and `music_enable` falls at edge t+2.
- `speaker` in MUSIC lags `music_speaker` by 1 cycle.
- **Effect length:** exactly 4×NOTE_TICKS cycles in SFX_PLAY.
  - `sfx_done` is high on the first SFX_GAP cycle.
  - `sfx_grant` stays valid through SFX_GAP and clears on exit.
- **Requests during an effect:** latched, never preempt, served after the gap.
- **`music_req` changes:**
  - Dropped during an effect: IDLE after the gap.
  - Dropped in MUSIC: IDLE and `music_enable`=0 on the next cycle.
- **First toggle:** `speaker` first toggles divider×PRESCALE cycles after note start, then every divider×PRESCALE cycles.

## Test plan
All scenarios use PRESCALE=1, NOTE_TICKS=2000, GAP_TICKS=100.
- **Reset:** hold `rst_n`=0 for 5 cycles with `music_req`=1 and `sfx_req`=4'hF → all outputs 0. After release, `music_enable`=1 two cycles later.
- **Single effect:**
  - Stimulus: music on, pulse `sfx_req`=4'b0010.
  - `music_enable` falls 2 cycles later and `sfx_grant`=4'b0010.
  - `speaker` half-periods are 270, 303, 341 and 383 cycles for 2000 cycles each.
  - `sfx_done` fires after 8000 cycles; music resumes 100 cycles later.
- **Priority:** pulse `sfx_req`=4'b1100 → effect 2 plays first, effect 3 next after the gap, then MUSIC. Two `sfx_done` pulses.
- **Merge/replay:**
  - Pulse `sfx_req[0]` three times while effect 0 plays → effect 0 replays exactly once.
  - A request on the grant cycle → the effect is also replayed once.
- **Music drop:**
  - Deassert `music_req` mid-effect → IDLE after the gap, `speaker`=0.
  - Deassert `music_req` in MUSIC → `music_enable`=0 on the next cycle.
- **Reset mid-effect:**
  - Pulse `rst_n` low during note 2 → immediate IDLE, no `sfx_done`, `pending` cleared.
  - After release, music resumes and the interrupted effect does not replay.
